// File: rtl/lmi_pkg.sv
// Shared constants, helpers and types for the multiport local memory interface.
package lmi_pkg;

   // Which SRAM port returned a port's completion data.
   typedef enum logic {
      PATH_RW = 1'b0,
      PATH_R  = 1'b1
   } lmi_path_e;

   // Byte lanes per data word.
   function automatic int unsigned lmi_bytes(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Number of byte-address bits below the word address.
   function automatic int unsigned lmi_byte_offset(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   // LSB position of slice 'index' in a flat bus of 'width'-bit slices.
   function automatic int unsigned lmi_slice_lsb(input int unsigned index,
                                                 input int unsigned width);
      return index * width;
   endfunction

endpackage

// File: rtl/lmi_rr_arbiter.sv
// Round-robin arbiter: combinational grant search from a registered pointer.
// The pointer moves just past the granted index whenever 'advance' is high.
module lmi_rr_arbiter #(
   parameter int unsigned NUM_PORTS   = 2,
   parameter int unsigned INDEX_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   request,
   input  logic                   advance,
   output logic [NUM_PORTS-1:0]   grant,
   output logic [INDEX_WIDTH-1:0] grant_index
);

   logic [INDEX_WIDTH-1:0] ptr;
   logic                   found;
   int unsigned            idx;

   // Pick the first requester at or after the pointer, wrapping around.
   always_comb begin
      grant       = '0;
      grant_index = '0;
      found       = 1'b0;
      idx         = 0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         idx = (32'(ptr) + k) % NUM_PORTS;
         if (!found && request[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_index = INDEX_WIDTH'(idx);
         end
      end
   end

   // Advance the pointer past the winner so it has lowest priority next time.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         if (32'(grant_index) == NUM_PORTS - 1) begin
            ptr <= '0;
         end else begin
            ptr <= grant_index + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lmi_multiport_rw_r.sv
// Multiport local memory interface onto one SRAM macro with an RW port and an
// R port. Reads by READ_OWNER use the R port without arbitration; everything
// else shares the RW port through a round-robin arbiter.
// Optional build macro LMI_ACCESS_ERROR_EN adds req_error and completes
// misaligned/out-of-range requests with an error pulse instead of ignoring them.
module lmi_multiport_rw_r
   import lmi_pkg::*;
#(
   parameter int unsigned NUM_PORTS         = 2,
   parameter int unsigned ADDRESS_SIZE      = 24,
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned SRAM_ADDRESS_SIZE = 9,
   parameter int unsigned READ_OWNER        = 0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]          req_address,
   input  logic [NUM_PORTS*lmi_bytes(DATA_WIDTH)-1:0] req_byte_select,
   input  logic [NUM_PORTS-1:0]                       req_enable,
   input  logic [NUM_PORTS-1:0]                       req_write_enable,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]            req_data_write,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]            req_data_read,
   output logic [NUM_PORTS-1:0]                       req_busy,
`ifdef LMI_ACCESS_ERROR_EN
   output logic [NUM_PORTS-1:0]                       req_error,
`endif
   output logic                                       sram_rw_select,
   output logic                                       sram_rw_write_enable,
   output logic [SRAM_ADDRESS_SIZE-1:0]               sram_rw_address,
   output logic [lmi_bytes(DATA_WIDTH)-1:0]           sram_rw_write_mask,
   output logic [DATA_WIDTH-1:0]                      sram_rw_data_write,
   input  logic [DATA_WIDTH-1:0]                      sram_rw_data_read,
   output logic                                       sram_r_select,
   output logic [SRAM_ADDRESS_SIZE-1:0]               sram_r_address,
   input  logic [DATA_WIDTH-1:0]                      sram_r_data_read
);

   localparam int unsigned BYTES       = lmi_bytes(DATA_WIDTH);
   localparam int unsigned BYTE_OFFSET = lmi_byte_offset(DATA_WIDTH);
   localparam int unsigned INDEX_WIDTH = $clog2(NUM_PORTS);
   localparam int unsigned RANGE_SHIFT = SRAM_ADDRESS_SIZE + BYTE_OFFSET;
   localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK =
      ADDRESS_SIZE'((64'd1 << BYTE_OFFSET) - 64'd1);

   logic [ADDRESS_SIZE-1:0]      addr      [NUM_PORTS];
   logic [SRAM_ADDRESS_SIZE-1:0] word_addr [NUM_PORTS];
   logic [BYTES-1:0]             sel       [NUM_PORTS];
   logic [DATA_WIDTH-1:0]        wdata     [NUM_PORTS];
   logic [BYTES-1:0]             last_sel  [NUM_PORTS];
   lmi_path_e                    path      [NUM_PORTS];

   logic [NUM_PORTS-1:0]   well_formed;
   logic [NUM_PORTS-1:0]   valid;
   logic [NUM_PORTS-1:0]   r_service;
   logic [NUM_PORTS-1:0]   eligible;
   logic [NUM_PORTS-1:0]   grant;
   logic [NUM_PORTS-1:0]   serviced;
   logic [NUM_PORTS-1:0]   err_service;
   logic [NUM_PORTS-1:0]   complete;
   logic [NUM_PORTS-1:0]   done;
   logic [INDEX_WIDTH-1:0] grant_index;
   logic                   advance;

   // Split the flat request buses and qualify each port's address.
   // Shifting by RANGE_SHIFT >= ADDRESS_SIZE yields zero, so the range check
   // disappears on its own when every byte address fits in the SRAM.
   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         addr[i]        = req_address[lmi_slice_lsb(i, ADDRESS_SIZE) +: ADDRESS_SIZE];
         sel[i]         = req_byte_select[lmi_slice_lsb(i, BYTES) +: BYTES];
         wdata[i]       = req_data_write[lmi_slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
         word_addr[i]   = SRAM_ADDRESS_SIZE'(addr[i] >> BYTE_OFFSET);
         well_formed[i] = ((addr[i] & ALIGN_MASK) == '0) &&
                          ((addr[i] >> RANGE_SHIFT) == '0);
         valid[i]       = req_enable[i] && well_formed[i];
      end
   end

   // Route READ_OWNER reads to the R port; everything else competes for RW.
   // Reset masks both so no SRAM select can rise while rst is high.
   always_comb begin
      r_service = '0;
      eligible  = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (i == READ_OWNER && !req_write_enable[i]) begin
            r_service[i] = !rst && valid[i] && !done[i];
         end else begin
            eligible[i]  = !rst && valid[i] && !done[i];
         end
      end
   end

   lmi_rr_arbiter #(
      .NUM_PORTS   (NUM_PORTS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_arbiter (
      .clk         (clk),
      .rst         (rst),
      .request     (eligible),
      .advance     (advance),
      .grant       (grant),
      .grant_index (grant_index)
   );

   // The pointer moves on every cycle the RW port is handed out.
   always_comb begin
      advance  = |grant;
      serviced = grant | r_service;
   end

   // Drive the RW port from the granted requester, idle zeros otherwise.
   always_comb begin
      sram_rw_select       = 1'b0;
      sram_rw_write_enable = 1'b0;
      sram_rw_address      = '0;
      sram_rw_write_mask   = '0;
      sram_rw_data_write   = '0;
      if (|grant) begin
         sram_rw_select       = 1'b1;
         sram_rw_write_enable = req_write_enable[grant_index];
         sram_rw_address      = word_addr[grant_index];
         sram_rw_write_mask   = sel[grant_index];
         sram_rw_data_write   = wdata[grant_index];
      end
   end

   // Drive the R port for the owner's read.
   always_comb begin
      sram_r_select  = |r_service;
      sram_r_address = (|r_service) ? word_addr[READ_OWNER] : '0;
   end

`ifdef LMI_ACCESS_ERROR_EN
   // Malformed requests finish in one cycle without touching the SRAM.
   always_comb begin
      err_service = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         err_service[i] = !rst && req_enable[i] && !well_formed[i] && !done[i];
      end
      complete = serviced | err_service;
      req_busy = req_enable & ~done;
   end

   // Error flag pulses alongside done for a malformed request.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_error <= '0;
      end else begin
         req_error <= err_service;
      end
   end
`else
   // Malformed requests are ignored: never busy, never complete.
   always_comb begin
      err_service = '0;
      complete    = serviced;
      req_busy    = valid & ~done;
   end
`endif

   // Completion bookkeeping: one-cycle done pulse, returned lanes and source.
   // Writes and error completions latch no lanes so they read back all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         done <= '0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            last_sel[i] <= '0;
            path[i]     <= PATH_RW;
         end
      end else begin
         done <= complete;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (complete[i]) begin
               last_sel[i] <= (serviced[i] && !req_write_enable[i]) ? sel[i] : '0;
               path[i]     <= r_service[i] ? PATH_R : PATH_RW;
            end
         end
      end
   end

   // Return SRAM bytes on completed, selected lanes; all-ones everywhere else.
   always_comb begin
      req_data_read = '1;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (done[i] && last_sel[i][b]) begin
               req_data_read[lmi_slice_lsb(i, DATA_WIDTH) + b*8 +: 8] =
                  (path[i] == PATH_R) ? sram_r_data_read[b*8 +: 8]
                                      : sram_rw_data_read[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_lmi_multiport_rw_r.sv
// Bench for lmi_multiport_rw_r (default parameters) with an SRAM model and a
// per-port queue of expected completions.
module tb_lmi_multiport_rw_r;

   localparam int NP = 2;
   localparam int AW = 24;
   localparam int DW = 32;
   localparam int SW = 9;
   localparam int BY = 4;
`ifdef LMI_ACCESS_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [NP*AW-1:0]   req_address;
   logic [NP*BY-1:0]   req_byte_select;
   logic [NP-1:0]      req_enable;
   logic [NP-1:0]      req_write_enable;
   logic [NP*DW-1:0]   req_data_write;
   logic [NP*DW-1:0]   req_data_read;
   logic [NP-1:0]      req_busy;
   logic [NP-1:0]      req_error;
   logic               sram_rw_select;
   logic               sram_rw_write_enable;
   logic [SW-1:0]      sram_rw_address;
   logic [BY-1:0]      sram_rw_write_mask;
   logic [DW-1:0]      sram_rw_data_write;
   logic [DW-1:0]      sram_rw_data_read;
   logic               sram_r_select;
   logic [SW-1:0]      sram_r_address;
   logic [DW-1:0]      sram_r_data_read;

   lmi_multiport_rw_r #(
      .NUM_PORTS         (NP),
      .ADDRESS_SIZE      (AW),
      .DATA_WIDTH        (DW),
      .SRAM_ADDRESS_SIZE (SW),
      .READ_OWNER        (0)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_address          (req_address),
      .req_byte_select      (req_byte_select),
      .req_enable           (req_enable),
      .req_write_enable     (req_write_enable),
      .req_data_write       (req_data_write),
      .req_data_read        (req_data_read),
      .req_busy             (req_busy),
`ifdef LMI_ACCESS_ERROR_EN
      .req_error            (req_error),
`endif
      .sram_rw_select       (sram_rw_select),
      .sram_rw_write_enable (sram_rw_write_enable),
      .sram_rw_address      (sram_rw_address),
      .sram_rw_write_mask   (sram_rw_write_mask),
      .sram_rw_data_write   (sram_rw_data_write),
      .sram_rw_data_read    (sram_rw_data_read),
      .sram_r_select        (sram_r_select),
      .sram_r_address       (sram_r_address),
      .sram_r_data_read     (sram_r_data_read)
   );

`ifndef LMI_ACCESS_ERROR_EN
   assign req_error = '0;
`endif

   initial forever #5 clk = ~clk;

   // SRAM macro model: registered reads, byte-masked writes.
   logic [DW-1:0] mem [512];
   always @(posedge clk) begin
      if (sram_rw_select) begin
         if (sram_rw_write_enable) begin
            for (int b = 0; b < BY; b++)
               if (sram_rw_write_mask[b]) mem[sram_rw_address][b*8 +: 8] <= sram_rw_data_write[b*8 +: 8];
         end else begin
            sram_rw_data_read <= mem[sram_rw_address];
         end
      end
      if (sram_r_select) sram_r_data_read <= mem[sram_r_address];
   end

   typedef struct {
      logic [DW-1:0] data;
      int            max_lat;
   } exp_t;

   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   int            grant_q[$];
   logic [DW-1:0] ref_mem [512];
   logic [NP-1:0] tracked;
   int            lat    [NP];
   int            refill [NP];
   bit            watch_grants;
   int            n_tests;
   int            n_fail;

   logic          snap_rw_sel, snap_rw_we, snap_r_sel;
   logic [SW-1:0] snap_rw_addr, snap_r_addr;
   logic [BY-1:0] snap_rw_mask;
   logic [DW-1:0] snap_rw_data;
   logic [NP-1:0] snap_busy, snap_err;
   logic [NP*DW-1:0] snap_rdata;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic raw(input int p, input logic [AW-1:0] a, input logic we,
                      input logic [BY-1:0] s, input logic [DW-1:0] d);
      req_address[p*AW +: AW]     = a;
      req_byte_select[p*BY +: BY] = s;
      req_write_enable[p]         = we;
      req_data_write[p*DW +: DW]  = d;
      req_enable[p]               = 1'b1;
   endtask

   task automatic issue(input int p, input logic [AW-1:0] a, input logic we,
                        input logic [BY-1:0] s, input logic [DW-1:0] d, input int max_lat);
      exp_t e;
      int   wi;
      raw(p, a, we, s, d);
      tracked[p] = 1'b1;
      lat[p]     = 0;
      wi         = int'(a[10:2]);
      e.max_lat  = max_lat;
      e.data     = '1;
      for (int b = 0; b < BY; b++) begin
         if (we && s[b]) ref_mem[wi][b*8 +: 8] = d[b*8 +: 8];
         if (!we && s[b]) e.data[b*8 +: 8] = ref_mem[wi][b*8 +: 8];
      end
      if (p == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic complete(input int p);
      exp_t e;
      int   have;
      have = (p == 0) ? exp_q0.size() : exp_q1.size();
      check_eq($sformatf("sb_pending_p%0d", p), 64'(have != 0), 64'd1);
      if (have != 0) begin
         e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check_eq($sformatf("rdata_p%0d", p), req_data_read[p*DW +: DW], e.data);
         check_eq($sformatf("latency_p%0d=%0d", p, lat[p]),
                  64'(lat[p] >= 1 && lat[p] <= e.max_lat), 64'd1);
      end
      if (refill[p] > 0) begin
         refill[p]--;
         issue(p, (p == 0) ? 24'h40 : 24'h80, 1'b1, 4'hF,
               ((p == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(refill[p]), 2);
      end else begin
         req_enable[p] = 1'b0;
         tracked[p]    = 1'b0;
      end
   endtask

   // One clock: snapshot outputs at negedge, score completions, then return
   // just after the next posedge.
   task automatic step();
      int g;
      int eg;
      @(negedge clk);
      snap_rw_sel  = sram_rw_select;
      snap_rw_we   = sram_rw_write_enable;
      snap_rw_addr = sram_rw_address;
      snap_rw_mask = sram_rw_write_mask;
      snap_rw_data = sram_rw_data_write;
      snap_r_sel   = sram_r_select;
      snap_r_addr  = sram_r_address;
      snap_busy    = req_busy;
      snap_err     = req_error;
      snap_rdata   = req_data_read;
      if (watch_grants && sram_rw_select) begin
         g  = (sram_rw_address == 9'd32) ? 1 : 0;
         eg = (grant_q.size() != 0) ? grant_q.pop_front() : -1;
         check_eq("grant_order", 64'(g), 64'(eg));
      end
      for (int p = 0; p < NP; p++) begin
         if (tracked[p]) begin
            if (req_busy[p]) lat[p]++;
            else complete(p);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while (tracked != '0 && n < budget) begin
         step();
         n++;
      end
      check_eq("idle_timeout", 64'(tracked), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [AW-1:0] inv_addr [3];
   int            inv_port [3];
   logic          inv_we   [3];

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      tracked          = '0;
      watch_grants     = 1'b0;
      refill           = '{0, 0};
      lat              = '{0, 0};
      req_address      = '0;
      req_byte_select  = '0;
      req_enable       = '0;
      req_write_enable = '0;
      req_data_write   = '0;
      #1;

      // Reset state.
      do_reset();
      check_eq("rst_rw_sel", 64'(snap_rw_sel), 64'd0);
      check_eq("rst_r_sel", 64'(snap_r_sel), 64'd0);
      step();
      check_eq("rst_busy", 64'(snap_busy), 64'd0);
      check_eq("rst_rdata", snap_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("rst_err", 64'(snap_err), 64'd0);

      // Preload word 4 through the RW port.
      issue(1, 24'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 1);
      run_idle(10);

      // Owner read on the R port, lower two lanes.
      issue(0, 24'h10, 1'b0, 4'b0011, 32'h0, 1);
      step();
      check_eq("t1_r_sel", 64'(snap_r_sel), 64'd1);
      check_eq("t1_r_addr", 64'(snap_r_addr), 64'd4);
      check_eq("t1_rw_sel", 64'(snap_rw_sel), 64'd0);
      check_eq("t1_busy", 64'(snap_busy[0]), 64'd1);
      run_idle(10);

      // Port 1 full-word write.
      issue(1, 24'h20, 1'b1, 4'hF, 32'h1234_5678, 1);
      step();
      check_eq("t2_rw_sel", 64'(snap_rw_sel), 64'd1);
      check_eq("t2_rw_we", 64'(snap_rw_we), 64'd1);
      check_eq("t2_rw_addr", 64'(snap_rw_addr), 64'd8);
      check_eq("t2_rw_mask", 64'(snap_rw_mask), 64'hF);
      check_eq("t2_rw_data", 64'(snap_rw_data), 64'h1234_5678);
      check_eq("t2_busy", 64'(snap_busy[1]), 64'd1);
      run_idle(10);

      // Non-owner read goes through RW; owner full read goes through R.
      issue(1, 24'h20, 1'b0, 4'b1100, 32'h0, 1);
      step();
      check_eq("rb_rw_we", 64'(snap_rw_we), 64'd0);
      check_eq("rb_r_sel", 64'(snap_r_sel), 64'd0);
      run_idle(10);
      issue(0, 24'h20, 1'b0, 4'hF, 32'h0, 1);
      run_idle(10);

      // Owner read and port-1 write in the same cycle.
      issue(0, 24'h10, 1'b0, 4'hF, 32'h0, 1);
      issue(1, 24'h30, 1'b1, 4'hF, 32'hA5A5_5A5A, 1);
      step();
      check_eq("cc_r_sel", 64'(snap_r_sel), 64'd1);
      check_eq("cc_rw_sel", 64'(snap_rw_sel), 64'd1);
      run_idle(10);

      // Both ports write back-to-back from rr_ptr = 0.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         grant_q.push_back(0);
         grant_q.push_back(1);
      end
      refill       = '{3, 3};
      watch_grants = 1'b1;
      issue(0, 24'h40, 1'b1, 4'hF, 32'hA000_0003, 2);
      issue(1, 24'h80, 1'b1, 4'hF, 32'hB000_0003, 2);
      run_idle(40);
      watch_grants = 1'b0;
      check_eq("grant_left", 64'(grant_q.size()), 64'd0);

      // Malformed requests: misaligned, out of range, misaligned owner read.
      inv_port = '{1, 1, 0};
      inv_addr = '{24'h000013, 24'h000800, 24'h000011};
      inv_we   = '{1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 3; c++) begin
         raw(inv_port[c], inv_addr[c], inv_we[c], 4'hF, 32'hCAFE_F00D);
         step();
         check_eq($sformatf("inv%0d_rw_sel", c), 64'(snap_rw_sel), 64'd0);
         check_eq($sformatf("inv%0d_r_sel", c), 64'(snap_r_sel), 64'd0);
         check_eq($sformatf("inv%0d_busy_t", c), 64'(snap_busy[inv_port[c]]), 64'(ERR_EN));
         check_eq($sformatf("inv%0d_err_t", c), 64'(snap_err[inv_port[c]]), 64'd0);
         step();
         check_eq($sformatf("inv%0d_busy_t1", c), 64'(snap_busy[inv_port[c]]), 64'd0);
         check_eq($sformatf("inv%0d_err_t1", c), 64'(snap_err[inv_port[c]]), 64'(ERR_EN));
         check_eq($sformatf("inv%0d_rdata", c), snap_rdata[inv_port[c]*DW +: DW], 64'hFFFF_FFFF);
         req_enable = '0;
         step();
      end

      // Reset asserted in a cycle where both ports would be arbitrated.
      raw(0, 24'h40, 1'b1, 4'hF, 32'h1111_1111);
      raw(1, 24'h80, 1'b1, 4'hF, 32'h2222_2222);
      rst = 1'b1;
      step();
      check_eq("mr_rw_sel", 64'(snap_rw_sel), 64'd0);
      check_eq("mr_r_sel", 64'(snap_r_sel), 64'd0);
      rst = 1'b0;
      step();
      check_eq("mr_busy", 64'(snap_busy), 64'h3);
      check_eq("mr_rdata", snap_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("mr_rw_sel_after", 64'(snap_rw_sel), 64'd1);
      check_eq("mr_grant_p0", 64'(snap_rw_addr), 64'd16);
      req_enable = '0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lmi_multiport_rw_r.md
Name: lmi_multiport_rw_r

Overview:
- Successor to the two-port local memory interface. Connects NUM_PORTS bus-side requestors to one SRAM macro with a read/write (RW) port and a read-only (R) port.
- One designated port, READ_OWNER, reads through the R port and never arbitrates.
- All other accesses share the RW port under registered round-robin arbitration.
- Generalised in port count, data width and SRAM depth. Sits between the core/wishbone/peripheral masters and the SRAM macro.

Parameters:
- NUM_PORTS, 2: number of requestor ports, 2..8.
- ADDRESS_SIZE, 24: requestor byte-address width.
- DATA_WIDTH, 32: data width; a multiple of 8, 8..64.
- SRAM_ADDRESS_SIZE, 9: SRAM word-address width.
- READ_OWNER, 0: index of the port whose reads use the R port.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_address  in  NUM_PORTS*ADDRESS_SIZE  byte address per port; port i occupies slice i.
- req_byte_select  in  NUM_PORTS*BYTES  byte lanes per port (BYTES = DATA_WIDTH/8).
- req_enable  in  NUM_PORTS  request valid.
- req_write_enable  in  NUM_PORTS  1 = write.
- req_data_write  in  NUM_PORTS*DATA_WIDTH  write data.
- req_data_read  out  NUM_PORTS*DATA_WIDTH  read data.
- req_busy  out  NUM_PORTS  request not yet complete.
- sram_rw_select  out  1  RW port chip select.
- sram_rw_write_enable  out  1  RW port write enable.
- sram_rw_address  out  SRAM_ADDRESS_SIZE  RW port word address.
- sram_rw_write_mask  out  BYTES  RW port byte write mask.
- sram_rw_data_write  out  DATA_WIDTH  RW port write data.
- sram_rw_data_read  in  DATA_WIDTH  RW port read data, valid one cycle after select.
- sram_r_select  out  1  R port chip select.
- sram_r_address  out  SRAM_ADDRESS_SIZE  R port word address.
- sram_r_data_read  in  DATA_WIDTH  R port read data, valid one cycle after select.

Behaviour:
- Valid request on port i:
  - req_enable[i] high.
  - Address low log2(BYTES) bits zero.
  - Address bits above SRAM_ADDRESS_SIZE+log2(BYTES) all zero; this check is omitted when the address fits.
- Invalid requests are ignored: busy stays low, no SRAM activity.
- Per-port done[i] register, reset 0.
  - Set at posedge T when port i is serviced in cycle T.
  - Cleared unconditionally the following posedge.
- req_busy[i] = valid[i] && !done[i].
- Latency: request serviced in cycle T -> done and data at T+1. Minimum latency 1 cycle.
- Master must drop enable or change request in cycle T+1. If enable is still high at T+2, the same request re-issues as a new access.
- R path: if port READ_OWNER issues a valid read and done is low, sram_r_select = 1 and sram_r_address = word address. Serviced the same cycle, no arbitration.
- RW eligible set: every valid, not-done request except reads by READ_OWNER.
- Grant: combinational round-robin starting at rr_ptr.
  - rr_ptr resets to 0.
  - On each grant, rr_ptr <= granted index + 1, wrapping NUM_PORTS-1 -> 0.
- RW port drive:
  - Any eligible request: sram_rw_select = 1; write_enable, address, write_mask and data_write are taken from the granted port.
  - No eligible request: all RW outputs 0.
- Ports not granted keep busy high and retry next cycle. There is no starvation: each port waits at most NUM_PORTS-1 grants.
- At done-set, byte_select[i] is latched into last_sel[i], reset 0.
- req_data_read slice i: for each byte lane b, sram byte if done[i] && last_sel[i][b], else 8'hFF.
  - Source is the R port data for READ_OWNER reads, otherwise the RW port data.
  - A 1-bit path flag per port selects the source.
  - Write completions return all-ones.
- Reset (applies mid-operation):
  - done, last_sel, path flags and rr_ptr all return to 0 next edge.
  - All SRAM selects and enables drop combinationally while rst is high.
  - Any in-flight access is abandoned.

Optional Feature:
- Macro LMI_ACCESS_ERROR_EN.
- Defined:
  - Adds output req_error [NUM_PORTS].
  - Invalid requests (misaligned or out of range) with enable high complete in 1 cycle: busy high for the request cycle, then req_error[i] and done pulse at T+1.
  - Data read is all-ones; no SRAM access is made.
- Undefined: port absent; invalid requests are ignored as described in Behaviour.

Decomposition:
- Package lmi_pkg holds:
  - BYTES and BYTE_OFFSET (clog2 of BYTES) as derived-constant functions.
  - A port-slice index helper.
  - An access-path enum {PATH_RW, PATH_R}.
- Sub-module lmi_rr_arbiter: NUM_PORTS request vector in, one-hot grant plus index out, registered pointer with advance input.

Test Plan:
- Port0 reads 0x000010, SRAM R port returns 0xDEADBEEF, byte_select 4'b0011 -> sram_r_address 4; at T+1 data_read 0xFFFFBEEF and busy low.
- Port1 writes 0x12345678 to 0x000020 with mask 4'b1111 -> in cycle T, RW select=1, write_enable=1, address 8, mask 4'hF; busy is high in T, low in T+1.
- Ports 0 and 1 both write every cycle with rr_ptr=0 -> grants alternate 0,1,0,1; neither busy lasts more than 2 cycles.
- Port0 reads while port1 writes in the same cycle -> R and RW selects both high in that cycle; both complete at T+1.
- Misaligned address 0x000013 or address 0x000800 (out of range, SRAM_ADDRESS_SIZE=9) -> no select, busy 0; with LMI_ACCESS_ERROR_EN, req_error pulses at T+1.
- rst asserted in the cycle a grant is issued -> at next edge done=0, rr_ptr=0, data_read all-ones, no completion pulse.
